sar_controller: RTL and testbench

SAR_CONTROLLER -- requirements
Module: sar_controller

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_settle_timer.sv | 32 +++
 rtl/sar_controller.sv | 96 +++++++++
 tb/tb_sar_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation ADC controller.
package sar_pkg;

    localparam int unsigned DEF_N_BITS     = 8;
    localparam int unsigned DEF_SETTLE_CYC = 2;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_e;

endpackage

// File: rtl/sar_settle_timer.sv
// DAC settling timer: load clears it, count advances it, expire flags the last settle cycle.
module sar_settle_timer
    import sar_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // expire is precomputed so it is high during the cycle in which cnt == LAST
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (load) begin
            cnt    <= '0;
            expire <= (SETTLE_CYC == 1);
        end else if (count) begin
            cnt    <= cnt + CNT_W'(1);
            expire <= ((cnt + CNT_W'(1)) == LAST);
        end
    end

endmodule

// File: rtl/sar_controller.sv
// Successive-approximation ADC controller: walks a one-hot trial bit from MSB to LSB,
// settling the DAC before each comparator strobe.
module sar_controller
    import sar_pkg::*;
#(
    parameter int unsigned N_BITS     = DEF_N_BITS,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              decision,
    output logic              cmp_strobe,
    output logic [N_BITS-1:0] dac_code,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] dout
);

    localparam logic [N_BITS-1:0] MSB = {1'b1, {(N_BITS-1){1'b0}}};

    sar_state_e        state;
    logic [N_BITS-1:0] trial_mask;
    logic [N_BITS-1:0] kept_c;
    logic              load_c;
    logic              count_c;
    logic              expire;

    // Resolve the bit under test and decide when the settle timer restarts or runs
    always_comb begin
        kept_c  = decision ? dac_code : (dac_code & ~trial_mask);
        load_c  = ((state == ST_IDLE) && start) ||
                  ((state == ST_COMPARE) && !trial_mask[0]);
        count_c = (state == ST_SETTLE) && !expire;
    end

    sar_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load_c),
        .count  (count_c),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            trial_mask <= '0;
            dac_code   <= '0;
            dout       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmp_strobe <= 1'b0;
        end else begin
            done       <= 1'b0;
            cmp_strobe <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SETTLE;
                        trial_mask <= MSB;
                        dac_code   <= MSB;
                        busy       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (expire) begin
                        state      <= ST_COMPARE;
                        cmp_strobe <= 1'b1;
                    end
                end
                ST_COMPARE: begin
                    // trial_mask[0] marks the LSB, i.e. the final decision
                    if (trial_mask[0]) begin
                        dac_code <= kept_c;
                        dout     <= kept_c;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        dac_code   <= kept_c | (trial_mask >> 1);
                        trial_mask <= trial_mask >> 1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_controller.sv
// Self-checking bench for sar_controller: default 8-bit instance plus a 4-bit, 1-cycle-settle instance.
module tb_sar_controller;

    logic       clk;
    logic       rst;
    logic       noise;

    logic       start_a;
    logic       decision_a;
    logic       cmp_strobe_a;
    logic [7:0] dac_a;
    logic       busy_a;
    logic       done_a;
    logic [7:0] dout_a;
    logic [7:0] tgt_a;
    int         mode_a;

    logic       start_b;
    logic       decision_b;
    logic       cmp_strobe_b;
    logic [3:0] dac_b;
    logic       busy_b;
    logic       done_b;
    logic [3:0] dout_b;
    logic [3:0] tgt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt_a = 0;
    int strobe_cnt_a = 0;
    int done_cnt_b = 0;

    logic [7:0] trial_q[$];
    logic [7:0] dout_q[$];
    logic [3:0] dout_q_b[$];
    logic [7:0] mon_exp;
    logic [3:0] mon_exp_b;

    // Comparator models; outside the strobe cycle the decision line carries noise
    assign decision_a = !cmp_strobe_a ? noise :
                        (mode_a == 1) ? 1'b1  :
                        (mode_a == 2) ? 1'b0  : (tgt_a >= dac_a);
    assign decision_b = !cmp_strobe_b ? noise : (tgt_b >= dac_b);

    sar_controller dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .decision   (decision_a),
        .cmp_strobe (cmp_strobe_a),
        .dac_code   (dac_a),
        .busy       (busy_a),
        .done       (done_a),
        .dout       (dout_a)
    );

    sar_controller #(.N_BITS(4), .SETTLE_CYC(1)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .decision   (decision_b),
        .cmp_strobe (cmp_strobe_b),
        .dac_code   (dac_b),
        .busy       (busy_b),
        .done       (done_b),
        .dout       (dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) noise = 1'($urandom);

    // Scoreboard: trial codes on each strobe, results on each done
    always @(negedge clk) begin
        if (cmp_strobe_a === 1'b1) begin
            strobe_cnt_a++;
            n_checks++;
            if (trial_q.size() == 0) begin
                n_fail++;
                $display("FAIL trial_seq: unexpected strobe with dac_code=%h, required no strobe", dac_a);
            end else begin
                mon_exp = trial_q.pop_front();
                if (dac_a !== mon_exp) begin
                    n_fail++;
                    $display("FAIL trial_seq: dac_code=%h required %h", dac_a, mon_exp);
                end
            end
        end
        if (done_a === 1'b1) begin
            done_cnt_a++;
            n_checks++;
            if (dout_q.size() == 0) begin
                n_fail++;
                $display("FAIL dout_a: unexpected done with dout=%h", dout_a);
            end else begin
                mon_exp = dout_q.pop_front();
                if (dout_a !== mon_exp) begin
                    n_fail++;
                    $display("FAIL dout_a: dout=%h required %h", dout_a, mon_exp);
                end
            end
        end
        if (done_b === 1'b1) begin
            done_cnt_b++;
            n_checks++;
            if (dout_q_b.size() == 0) begin
                n_fail++;
                $display("FAIL dout_b: unexpected done with dout=%h", dout_b);
            end else begin
                mon_exp_b = dout_q_b.pop_front();
                if (dout_b !== mon_exp_b) begin
                    n_fail++;
                    $display("FAIL dout_b: dout=%h required %h", dout_b, mon_exp_b);
                end
            end
        end
    end

    // Reference binary search: push expected trial codes and final result
    task automatic push_model(input logic [7:0] t);
        logic [7:0] res;
        logic [7:0] trial;
        logic [7:0] one;
        res = 8'h00;
        one = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            trial = res | (one << i);
            trial_q.push_back(trial);
            if (t >= trial) res = trial;
        end
        dout_q.push_back(res);
    endtask

    // Run one conversion on dut_a; lat = cycles from accepting edge to done, -1 on timeout
    task automatic run_conv(input logic [7:0] tgt, input int mode, input bit poke, output int lat);
        int n;
        tgt_a  = tgt;
        mode_a = mode;
        push_model((mode == 1) ? 8'hFF : (mode == 2) ? 8'h00 : tgt);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n   = 0;
        lat = -1;
        while (n < 60 && lat < 0) begin
            @(negedge clk);
            n++;
            if (poke) start_a = (n == 4 || n == 22 || n == 24);
            if (done_a === 1'b1) lat = n;
        end
        if (poke) @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_a, done_a, cmp_strobe_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/strobe=%b required 000", {busy_a, done_a, cmp_strobe_a});
        end
        n_checks++;
        if (dac_a !== 8'h00 || dout_a !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: dac=%h dout=%h required 00 00", dac_a, dout_a);
        end
        n_checks++;
        if ({busy_b, done_b, cmp_strobe_b} !== 3'b000 || dac_b !== 4'h0 || dout_b !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_b: ctrl=%b dac=%h dout=%h required 000 0 0",
                     {busy_b, done_b, cmp_strobe_b}, dac_b, dout_b);
        end
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_conv: busy_a=%b busy_b=%b required 0 0", busy_a, busy_b);
        end
    endtask

    task automatic test_basic();
        int lat;
        int d0;
        int s0;
        d0 = done_cnt_a;
        s0 = strobe_cnt_a;
        run_conv(8'hA5, 0, 1'b0, lat);
        n_checks++;
        if (lat != 24) begin
            n_fail++;
            $display("FAIL basic_latency: %0d cycles required 24", lat);
        end
        n_checks++;
        if (strobe_cnt_a - s0 != 8) begin
            n_fail++;
            $display("FAIL basic_strobes: %0d required 8", strobe_cnt_a - s0);
        end
        @(negedge clk);
        n_checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b busy=%b after DONE required 0 0", done_a, busy_a);
        end
        n_checks++;
        if (dac_a !== 8'hA5 || dout_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_hold: dac=%h dout=%h required a5 a5", dac_a, dout_a);
        end
        n_checks++;
        if (done_cnt_a - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_done_count: %0d required 1", done_cnt_a - d0);
        end
    endtask

    task automatic test_stuck();
        int lat;
        int d0;
        for (int m = 1; m <= 2; m++) begin
            d0 = done_cnt_a;
            run_conv(8'h00, m, 1'b0, lat);
            repeat (4) @(negedge clk);
            n_checks++;
            if (dout_a !== ((m == 1) ? 8'hFF : 8'h00) || lat != 24) begin
                n_fail++;
                $display("FAIL stuck_%0d: dout=%h lat=%0d required %h 24",
                         m, dout_a, lat, (m == 1) ? 8'hFF : 8'h00);
            end
            n_checks++;
            if (done_cnt_a - d0 != 1) begin
                n_fail++;
                $display("FAIL stuck_%0d_done_count: %0d required 1", m, done_cnt_a - d0);
            end
        end
        mode_a = 0;
    endtask

    task automatic test_ignore_start();
        int lat;
        int d0;
        int s0;
        d0 = done_cnt_a;
        s0 = strobe_cnt_a;
        run_conv(8'h5A, 0, 1'b1, lat);
        repeat (4) @(negedge clk);
        n_checks++;
        if (lat != 24 || dout_a !== 8'h5A) begin
            n_fail++;
            $display("FAIL ignore_start: lat=%0d dout=%h required 24 5a", lat, dout_a);
        end
        n_checks++;
        if (done_cnt_a - d0 != 1 || strobe_cnt_a - s0 != 8 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_count: done=%0d strobes=%0d busy=%b required 1 8 0",
                     done_cnt_a - d0, strobe_cnt_a - s0, busy_a);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int d0;
        tgt_a = 8'h77;
        push_model(8'h77);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (10) @(negedge clk);
        d0 = done_cnt_a;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || cmp_strobe_a !== 1'b0 ||
            dac_a !== 8'h00 || dout_a !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b done=%b strobe=%b dac=%h dout=%h required 0 0 0 00 00",
                     busy_a, done_a, cmp_strobe_a, dac_a, dout_a);
        end
        trial_q.delete();
        dout_q.delete();
        dout_q_b.delete();
        repeat (30) @(negedge clk);
        n_checks++;
        if (done_cnt_a != d0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done_count_delta=%0d busy=%b required 0 0",
                     done_cnt_a - d0, busy_a);
        end
        run_conv(8'h3C, 0, 1'b0, lat);
        n_checks++;
        if (lat != 24 || dout_a !== 8'h3C) begin
            n_fail++;
            $display("FAIL after_abort: lat=%0d dout=%h required 24 3c", lat, dout_a);
        end
        @(negedge clk);
    endtask

    task automatic test_small();
        int n;
        int lat;
        tgt_b = 4'h9;
        dout_q_b.push_back(4'h9);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n   = 0;
        lat = -1;
        while (n < 30 && lat < 0) begin
            @(negedge clk);
            n++;
            if (done_b === 1'b1) lat = n;
        end
        n_checks++;
        if (lat != 8) begin
            n_fail++;
            $display("FAIL small_latency: %0d cycles required 8", lat);
        end
        n_checks++;
        if (dout_b !== 4'h9) begin
            n_fail++;
            $display("FAIL small_dout: %h required 9", dout_b);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        tgt_a   = 8'h00;
        tgt_b   = 4'h0;
        mode_a  = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stuck();
        test_ignore_start();
        test_reset_mid();
        test_small();
        n_checks++;
        if (trial_q.size() != 0 || dout_q.size() != 0 || dout_q_b.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: trial=%0d dout=%0d dout_b=%0d left, required 0 0 0",
                     trial_q.size(), dout_q.size(), dout_q_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
